// File: rtl/loader_pkg.sv
// loader_pkg: shared states and byte/word geometry for the instruction-memory loader.
package loader_pkg;
  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    WRITE,
    DONE,
    ERR
  } state_t;
  localparam int BYTE_WIDTH     = 8;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_WIDTH     = BYTE_WIDTH * BYTES_PER_WORD;
  localparam int IDX_WIDTH      = $clog2(BYTES_PER_WORD);
endpackage

// File: rtl/instr_mem_loader_byte_packer.sv
// byte_packer: lane-indexed little-endian word assembly; word already shows the lane being loaded.
module byte_packer
  import loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  load,
  input  logic [BYTE_WIDTH-1:0] byte_data,
  output logic [WORD_WIDTH-1:0] word,
  output logic                  last_byte
);
  logic [WORD_WIDTH-1:0] r_word;
  logic [IDX_WIDTH-1:0]  r_idx;
  logic [WORD_WIDTH-1:0] w_merged;
  always_comb begin
    w_merged = r_word;
    if (load) w_merged[r_idx*BYTE_WIDTH +: BYTE_WIDTH] = byte_data;
  end
  assign word      = w_merged;
  assign last_byte = r_idx == IDX_WIDTH'(BYTES_PER_WORD - 1);
  // The index wraps to lane 0 naturally after the last lane.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_word <= '0;
      r_idx  <= '0;
    end else if (load) begin
      r_word <= w_merged;
      r_idx  <= r_idx + 1'b1;
    end
  end
endmodule

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: streams a length-prefixed byte image into instruction memory,
// holding the CPU in reset until the whole image is written.
module instr_mem_loader
  import loader_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32,
  parameter int WORD_COUNT    = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     byte_valid,
  input  logic [7:0]               byte_data,
  output logic                     byte_ready,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wd,
  output logic                     cpu_rst,
  output logic                     done,
  output logic                     error
);
  localparam logic [16:0] MAX_LEN = 17'(WORD_COUNT);
  state_t                   r_state, w_next;
  logic [7:0]               r_len_lo;
  logic [15:0]              r_words_left;
  logic [ADDRESS_WIDTH-1:0] r_mem_addr;
  logic                     r_mem_we;
  logic [DATA_WIDTH-1:0]    r_mem_wd;
  logic                     w_accept, w_clear, w_last, w_bad_len;
  logic [15:0]              w_len;
  logic [WORD_WIDTH-1:0]    w_word;
  assign byte_ready = r_state inside {LEN_LO, LEN_HI, DATA};
  assign w_accept   = byte_valid && byte_ready;
  assign w_clear    = start && (r_state inside {IDLE, DONE, ERR});
  assign w_len      = {byte_data, r_len_lo};
  assign w_bad_len  = w_len == 16'd0 || {1'b0, w_len} > MAX_LEN;
  byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (w_clear),
    .load      (w_accept && r_state == DATA),
    .byte_data (byte_data),
    .word      (w_word),
    .last_byte (w_last)
  );
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE, ERR: w_next = start ? LEN_LO : r_state;
      LEN_LO:          w_next = w_accept ? LEN_HI : LEN_LO;
      LEN_HI:          w_next = !w_accept ? LEN_HI : (w_bad_len ? ERR : DATA);
      DATA:            w_next = (w_accept && w_last) ? WRITE : DATA;
      WRITE:           w_next = r_words_left == 16'd1 ? DONE : DATA;
      default:         w_next = IDLE;
    endcase
  end
  // The write strobe is registered on the last byte's accept edge, so it lines up with WRITE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_len_lo     <= '0;
      r_words_left <= '0;
      r_mem_addr   <= '0;
      r_mem_we     <= 1'b0;
      r_mem_wd     <= '0;
    end else begin
      r_state  <= w_next;
      r_mem_we <= w_accept && r_state == DATA && w_last;
      if (w_accept && r_state == DATA && w_last) r_mem_wd <= w_word;
      if (w_clear) r_mem_addr <= '0;
      else if (r_state == WRITE) r_mem_addr <= r_mem_addr + ADDRESS_WIDTH'(BYTES_PER_WORD);
      if (w_accept && r_state == LEN_LO) r_len_lo <= byte_data;
      if (w_accept && r_state == LEN_HI) r_words_left <= w_len;
      else if (r_state == WRITE) r_words_left <= r_words_left - 16'd1;
    end
  end
  assign mem_we   = r_mem_we;
  assign mem_addr = r_mem_addr;
  assign mem_wd   = r_mem_wd;
  assign cpu_rst  = r_state != DONE;
  assign done     = r_state == DONE;
  assign error    = r_state == ERR;
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: directed checks of image loading, length errors, mid-session reset and restart.
module tb_instr_mem_loader;
  logic        clk = 1'b0;
  logic        rst, start, byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready, mem_we, cpu_rst, done, error;
  logic [15:0] mem_addr;
  logic [31:0] mem_wd;
  int          total = 0;
  int          bad = 0;
  int          wr_cnt = 0;
  always #5 clk = ~clk;
  instr_mem_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wd     (mem_wd),
    .cpu_rst    (cpu_rst),
    .done       (done),
    .error      (error)
  );
  always @(negedge clk) if (mem_we === 1'b1) wr_cnt++;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic send_byte(input logic [7:0] b, input int gap);
    logic acc;
    int   n;
    byte_valid = 1'b0;
    repeat (gap) tick();
    byte_valid = 1'b1;
    byte_data  = b;
    n = 0;
    do begin
      acc = byte_ready;
      tick();
      n++;
    end while (!acc && n < 50);
    chk("byte_accept", {31'b0, acc}, 32'd1);
  endtask
  task automatic send_word(input logic [31:0] w, input logic [15:0] addr, input int maxgap);
    for (int i = 0; i < 4; i++)
      send_byte(w[8*i +: 8], maxgap > 0 ? int'($urandom_range(0, maxgap)) : 0);
    chk("write_we", {31'b0, mem_we}, 32'd1);
    chk("write_addr", {16'b0, mem_addr}, {16'b0, addr});
    chk("write_data", mem_wd, w);
  endtask
  task automatic finish_ok(input int exp_writes);
    byte_valid = 1'b0;
    tick();
    chk("done", {31'b0, done}, 32'd1);
    chk("cpu_rst_low", {31'b0, cpu_rst}, 32'd0);
    chk("write_count", wr_cnt, exp_writes);
  endtask
  initial begin
    rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    tick();
    tick();
    chk("rst_cpu_rst", {31'b0, cpu_rst}, 32'd1);
    chk("rst_we", {31'b0, mem_we}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_error", {31'b0, error}, 32'd0);
    chk("rst_ready", {31'b0, byte_ready}, 32'd0);
    chk("rst_addr", {16'b0, mem_addr}, 32'd0);
    rst = 1'b0;
    tick();
    // two-word image, back-to-back
    wr_cnt = 0;
    start_pulse();
    chk("lenlo_ready", {31'b0, byte_ready}, 32'd1);
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    chk("data_cpu_rst", {31'b0, cpu_rst}, 32'd1);
    send_word(32'h0FF00513, 16'h0000, 0);
    chk("write_ready_low", {31'b0, byte_ready}, 32'd0);
    send_word(32'h00100593, 16'h0004, 0);
    finish_ok(2);
    // restart from DONE with random gaps; overwrites from address 0
    wr_cnt = 0;
    start_pulse();
    chk("restart_cpu_rst", {31'b0, cpu_rst}, 32'd1);
    chk("restart_done", {31'b0, done}, 32'd0);
    send_byte(8'h02, 3);
    send_byte(8'h00, 2);
    send_word(32'h0FF00513, 16'h0000, 5);
    send_word(32'h00100593, 16'h0004, 5);
    finish_ok(2);
    repeat (3) tick();
    chk("no_extra_writes", wr_cnt, 2);
    // zero-length header
    wr_cnt = 0;
    start_pulse();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    byte_valid = 1'b0;
    chk("len0_error", {31'b0, error}, 32'd1);
    chk("len0_cpu_rst", {31'b0, cpu_rst}, 32'd1);
    repeat (3) tick();
    chk("len0_no_write", wr_cnt, 0);
    // 257 words exceeds capacity
    start_pulse();
    chk("err_cleared", {31'b0, error}, 32'd0);
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    byte_valid = 1'b0;
    chk("len257_error", {31'b0, error}, 32'd1);
    repeat (2) tick();
    chk("len257_no_write", wr_cnt, 0);
    // recovery load of one word
    start_pulse();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    chk("recover_no_error", {31'b0, error}, 32'd0);
    send_word(32'h44332211, 16'h0000, 0);
    finish_ok(1);
    // reset after two data bytes drops the partial word
    wr_cnt = 0;
    start_pulse();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    byte_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_ready", {31'b0, byte_ready}, 32'd0);
    chk("midrst_cpu_rst", {31'b0, cpu_rst}, 32'd1);
    chk("midrst_done", {31'b0, done}, 32'd0);
    repeat (3) tick();
    chk("midrst_no_write", wr_cnt, 0);
    start_pulse();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_word(32'h04030201, 16'h0000, 0);
    finish_ok(1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
